// File: rtl/idct_write_s.sv
// idct_write_s: drains one 8x8 S block, clips to 8-bit pixels, packs pairs and writes them to the YUV area of SRAM
module idct_write_s (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        WS_start,
  output logic        WS_done,
  output logic        WS_frame_done,
  output logic [6:0]  S_read_address,
  input  logic [31:0] S_read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  typedef enum logic [2:0] {WS_IDLE, WS_LEAD, WS_EVEN, WS_ODD, WS_FINISH} ws_state_t;

  localparam logic [1:0] SEG_Y = 2'd0;
  localparam logic [1:0] SEG_U = 2'd1;
  localparam logic [1:0] SEG_V = 2'd2;

  ws_state_t   r_state;
  logic [4:0]  r_k;
  logic [4:0]  r_rb;
  logic [5:0]  r_cb;
  logic [1:0]  r_seg;
  logic [7:0]  r_even;

  logic [31:0] w_p;
  logic [7:0]  w_pix;
  logic [7:0]  w_row;
  logic [17:0] w_row18;
  logic [17:0] w_row_off;
  logic [17:0] w_base;
  logic [17:0] w_addr;
  logic [6:0]  w_next_ra;
  logic        w_last_col;
  logic        w_last_row;
  logic        w_last_seg;

  // pixel clipping, word address from block position and word index (shift-add pitch), counter wrap flags
  always_comb begin
    w_p        = $signed(S_read_data) >>> 16;
    w_pix      = w_p[31] ? 8'd0 : (|w_p[30:8]) ? 8'd255 : w_p[7:0];
    w_row      = {r_rb, r_k[4:2]};
    w_row18    = {10'd0, w_row};
    w_row_off  = (r_seg == SEG_Y) ? (w_row18 << 7) + (w_row18 << 5) : (w_row18 << 6) + (w_row18 << 4);
    w_base     = (r_seg == SEG_U) ? 18'd38400 : (r_seg == SEG_V) ? 18'd57600 : 18'd0;
    w_addr     = w_base + w_row_off + {10'd0, r_cb, r_k[1:0]};
    w_next_ra  = (S_read_address == 7'd63) ? S_read_address : S_read_address + 7'd1;
    w_last_col = (r_seg == SEG_Y) ? (r_cb == 6'd39) : (r_cb == 6'd19);
    w_last_row = (r_rb == 5'd29);
    w_last_seg = (r_seg == SEG_V);
  end

  // block sequencer: issue 64 reads, pair pixels into 32 writes, then advance the block position
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state         <= WS_IDLE;
      r_k             <= 5'd0;
      r_rb            <= 5'd0;
      r_cb            <= 6'd0;
      r_seg           <= SEG_Y;
      r_even          <= 8'd0;
      WS_done         <= 1'b0;
      WS_frame_done   <= 1'b0;
      S_read_address  <= 7'd0;
      SRAM_address    <= 18'd0;
      SRAM_write_data <= 16'd0;
      SRAM_we_n       <= 1'b1;
    end else begin
      WS_done       <= 1'b0;
      WS_frame_done <= 1'b0;
      case (r_state)
        WS_IDLE: begin
          if (WS_start) begin
            r_state        <= WS_LEAD;
            r_k            <= 5'd0;
            S_read_address <= 7'd0;
          end
        end
        WS_LEAD: begin
          S_read_address <= w_next_ra;
          r_state        <= WS_EVEN;
        end
        WS_EVEN: begin
          r_even         <= w_pix;
          SRAM_we_n      <= 1'b1;
          S_read_address <= w_next_ra;
          r_state        <= WS_ODD;
        end
        WS_ODD: begin
          SRAM_write_data <= {r_even, w_pix};
          SRAM_address    <= w_addr;
          SRAM_we_n       <= 1'b0;
          S_read_address  <= w_next_ra;
          r_k             <= r_k + 5'd1;
          r_state         <= (r_k == 5'd31) ? WS_FINISH : WS_EVEN;
        end
        WS_FINISH: begin
          SRAM_we_n <= 1'b1;
          WS_done   <= 1'b1;
          r_state   <= WS_IDLE;
          if (w_last_col) begin
            r_cb <= 6'd0;
            if (w_last_row) begin
              r_rb          <= 5'd0;
              r_seg         <= w_last_seg ? SEG_Y : r_seg + 2'd1;
              WS_frame_done <= w_last_seg;
            end else begin
              r_rb <= r_rb + 5'd1;
            end
          end else begin
            r_cb <= r_cb + 6'd1;
          end
        end
        default: r_state <= WS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idct_write_s.sv
// tb_idct_write_s: directed vectors for the S-to-SRAM write-back stage
module tb_idct_write_s;

  logic        clk;
  logic        resetn;
  logic        WS_start;
  logic        WS_done;
  logic        WS_frame_done;
  logic [6:0]  S_read_address;
  logic [31:0] S_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  logic [31:0] s_mem [64];
  logic [17:0] cap_addr [32];
  logic [15:0] cap_data [32];
  logic        last_fd;
  int          b;
  int          n_chk;
  int          n_fail;

  idct_write_s dut (
    .CLOCK_50_I      (clk),
    .resetn          (resetn),
    .WS_start        (WS_start),
    .WS_done         (WS_done),
    .WS_frame_done   (WS_frame_done),
    .S_read_address  (S_read_address),
    .S_read_data     (S_read_data),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // S dual-port RAM read port with one cycle of latency
  always @(posedge clk) S_read_data <= s_mem[S_read_address[5:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int exp_addr(input int blk, input int k);
    int i, cols, base, pitch;
    if (blk < 1200) begin i = blk; cols = 40; base = 0; pitch = 160; end
    else if (blk < 1800) begin i = blk - 1200; cols = 20; base = 38400; pitch = 80; end
    else begin i = blk - 1800; cols = 20; base = 57600; pitch = 80; end
    return base + (8 * (i / cols) + k / 4) * pitch + 4 * (i % cols) + k % 4;
  endfunction

  task automatic ramp();
    for (int i = 0; i < 64; i++) s_mem[i] = i << 16;
  endtask

  task automatic run_block(input int mid);
    int bt, ba;
    bt = 0;
    ba = 0;
    last_fd = 1'b0;
    WS_start = 1'b1;
    for (int n = 1; n <= 67; n++) begin
      @(negedge clk);
      WS_start = (n == mid);
      if (SRAM_we_n !== !(n % 2 == 0 && n >= 4 && n <= 66)) bt++;
      if (n >= 4 && n <= 66 && !SRAM_we_n) begin
        cap_addr[(n - 4) / 2] = SRAM_address;
        cap_data[(n - 4) / 2] = SRAM_write_data;
      end
      if (n <= 64 && S_read_address !== 7'(n - 1)) ba++;
      if (WS_done !== (n == 67)) bt++;
      if (n < 67 && WS_frame_done !== 1'b0) bt++;
      if (n == 67) last_fd = WS_frame_done;
    end
    chk("we_done_timing", bt, 0);
    chk("s_read_seq", ba, 0);
    chk("frame_done", {31'd0, last_fd}, {31'd0, b == 2399});
    chk("word0_addr", {14'd0, cap_addr[0]}, exp_addr(b, 0));
    chk("word31_addr", {14'd0, cap_addr[31]}, exp_addr(b, 31));
    b = (b + 1) % 2400;
  endtask

  initial begin
    int bad;
    n_chk = 0;
    n_fail = 0;
    b = 0;
    resetn = 1'b0;
    WS_start = 1'b0;
    ramp();
    repeat (3) @(negedge clk);
    chk("rst_done", {31'd0, WS_done}, 0);
    chk("rst_frame_done", {31'd0, WS_frame_done}, 0);
    chk("rst_we_n", {31'd0, SRAM_we_n}, 1);
    chk("rst_addr", {14'd0, SRAM_address}, 0);
    chk("rst_wdata", {16'd0, SRAM_write_data}, 0);
    chk("rst_raddr", {25'd0, S_read_address}, 0);
    resetn = 1'b1;
    @(negedge clk);

    run_block(0);
    for (int k = 0; k < 32; k++) begin
      chk("ramp_addr", {14'd0, cap_addr[k]}, (k / 4) * 160 + k % 4);
      chk("ramp_data", {16'd0, cap_data[k]}, ((2 * k) << 8) | (2 * k + 1));
    end
    chk("ramp_first", {16'd0, cap_data[0]}, 32'h0001);
    chk("ramp_last", {16'd0, cap_data[31]}, 32'h3E3F);
    chk("ramp_last_addr", {14'd0, cap_addr[31]}, 1123);

    s_mem[0] = 32'hFFFF_0000;
    s_mem[1] = 300 << 16;
    s_mem[2] = (255 << 16) + 32'h0000_FFFF;
    s_mem[3] = 32'h0000_FFFF;
    run_block(0);
    chk("clip_word0", {16'd0, cap_data[0]}, 32'h00FF);
    chk("clip_word1", {16'd0, cap_data[1]}, 32'hFF00);
    ramp();

    while (b < 39) run_block(0);
    run_block(0);
    chk("blk39_word0", {14'd0, cap_addr[0]}, 156);
    run_block(0);
    chk("blk40_word0", {14'd0, cap_addr[0]}, 1280);

    force dut.r_seg = 2'd0;
    force dut.r_rb = 5'd29;
    force dut.r_cb = 6'd38;
    @(negedge clk);
    release dut.r_seg;
    release dut.r_rb;
    release dut.r_cb;
    b = 1198;
    run_block(0);
    run_block(0);
    run_block(0);
    chk("blk1200_word0", {14'd0, cap_addr[0]}, 38400);
    chk("blk1200_row1", {14'd0, cap_addr[4]}, 38480);

    force dut.r_seg = 2'd1;
    force dut.r_rb = 5'd29;
    force dut.r_cb = 6'd19;
    @(negedge clk);
    release dut.r_seg;
    release dut.r_rb;
    release dut.r_cb;
    b = 1799;
    run_block(0);
    run_block(0);
    chk("blk1800_word0", {14'd0, cap_addr[0]}, 57600);

    force dut.r_seg = 2'd2;
    force dut.r_rb = 5'd29;
    force dut.r_cb = 6'd18;
    @(negedge clk);
    release dut.r_seg;
    release dut.r_rb;
    release dut.r_cb;
    b = 2398;
    run_block(0);
    chk("blk2398_no_fd", {31'd0, last_fd}, 0);
    run_block(0);
    chk("blk2399_word31", {14'd0, cap_addr[31]}, 76799);
    chk("blk2399_fd", {31'd0, last_fd}, 1);
    run_block(0);
    chk("wrap_word0", {14'd0, cap_addr[0]}, 0);

    run_block(30);
    chk("midstart_word0", {14'd0, cap_addr[0]}, 4);
    run_block(0);
    chk("midstart_next", {14'd0, cap_addr[0]}, 8);

    WS_start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      WS_start = 1'b0;
    end
    chk("abort_we_before", {31'd0, SRAM_we_n}, 0);
    resetn = 1'b0;
    #1;
    chk("abort_we_n", {31'd0, SRAM_we_n}, 1);
    chk("abort_addr", {14'd0, SRAM_address}, 0);
    chk("abort_wdata", {16'd0, SRAM_write_data}, 0);
    chk("abort_raddr", {25'd0, S_read_address}, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (WS_done !== 1'b0 || SRAM_we_n !== 1'b1) bad++;
    end
    chk("abort_quiet", bad, 0);
    b = 0;
    run_block(0);
    chk("abort_restart", {14'd0, cap_addr[0]}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/idct_write_s.md
# idct_write_s

Write-back stage of the milestone-2 inverse-transform pipeline. It sits directly downstream of the T/S matrix-multiply stage. Each invocation drains one 8x8 block of S values (64 signed 32-bit accumulator results) from the S dual-port RAM, scales and clips them to 8-bit pixels, packs two pixels per 16-bit word, and writes the 32 words to the YUV pre-upsampling area of SRAM. The block keeps its own block-position counters across invocations and walks the Y, U and V segments in raster block order.

## Interface
- No parameters. Segment geometry is fixed:
  - Y: base 0, row pitch 160 words, 40 block columns.
  - U: base 38400, pitch 80, 20 block columns.
  - V: base 57600, pitch 80, 20 block columns.
  - All segments: 30 block rows.
- CLOCK_50_I  in  1  50 MHz clock
- resetn  in  1  asynchronous, active-low reset
- WS_start  in  1  single-cycle pulse; start write-back of the current block
- WS_done  out  1  single-cycle pulse; block fully written
- WS_frame_done  out  1  pulses with WS_done on the last V block (block 2399)
- S_read_address  out  7  S RAM read address; S is stored row-major at 0..63
- S_read_data  in  32  S RAM read data; registered, 1-cycle latency
- SRAM_address  out  18  SRAM word address
- SRAM_write_data  out  16  {even pixel[15:8], odd pixel[7:0]}
- SRAM_we_n  out  1  active-low SRAM write enable

## Operation
- States:
  - WS_IDLE: waits for WS_start.
  - WS_LEAD: first read is in flight.
  - WS_EVEN and WS_ODD: alternate through the block.
  - WS_FINISH: closes out the block and advances counters.
- Reads: S_read_address takes 0,1,…,63 on consecutive cycles starting the cycle after WS_start is sampled. One read is issued per cycle with no gaps.
- Pixel conversion: p = S_read_data >>> 16 (arithmetic). If p < 0, pixel = 0. If p > 255, pixel = 255. Otherwise pixel = p[7:0].
- WS_EVEN: latch the converted S[2k] into the even register. SRAM_we_n = 1.
- WS_ODD: register SRAM_write_data = {even, convert(S[2k+1])} and SRAM_address, and drive SRAM_we_n = 0.
- Address of word k (k = 0..31), with row r = k[4:2] and column c = k[1:0]:
  - address = base + (8·RB + r)·pitch + 4·CB + c
  - Compute with shifts and adds only: 160 = 128 + 32, 80 = 64 + 16. No multiplier.
- Counter advance happens in WS_FINISH:
  - CB increments.
  - At the segment's last column, CB returns to 0 and RB increments.
  - At RB = 29, RB returns to 0 and the segment advances Y→U→V.
  - After the last V block, the segment returns to Y and WS_frame_done pulses.
- WS_start is ignored outside WS_IDLE.
- Reset values: WS_done = 0, WS_frame_done = 0, SRAM_we_n = 1, SRAM_address = 0, SRAM_write_data = 0, S_read_address = 0. Counters RB = CB = 0, segment Y, state WS_IDLE.
- Reset asserted mid-block aborts immediately to the reset values. A partially written block is not resumed.

## Timing
- Cycle numbering: cycle 0 is the cycle in which WS_start is sampled high in WS_IDLE.
- Address n is presented in cycle n+1.
- S[n] is valid on S_read_data in cycle n+2:
  - WS_EVEN occupies the even cycles 2..64.
  - WS_ODD occupies the odd cycles 3..65.
- Word k is written (SRAM_we_n low, address and data stable) in cycle 2k+4. So we_n is low in cycles 4, 6, …, 66 and high in between.
- WS_done (and WS_frame_done where applicable) is high in cycle 67 only. The block is back in WS_IDLE in cycle 67.
- WS_start is accepted again in cycle 67. Back-to-back blocks cost 67 cycles each.
- SRAM_we_n is never low outside a block.

## Test plan
- Reset, then a block with S[n] = n<<16:
  - 32 writes at addresses 0,1,2,3,160,…,1123.
  - First data 0x0001, last data 0x3E3F.
  - WS_done in cycle 67.
- Clipping, with S[0] = 0xFFFF_0000 (−1), S[1] = 300<<16, S[2] = 255<<16 + 0xFFFF, S[3] = 0x0000_FFFF:
  - Word 0 = 0x00FF.
  - Word 1 = 0xFF00.
- Row wrap in Y, 40 blocks back-to-back:
  - Block 39 word 0 at address 156.
  - Block 40 (RB = 1) word 0 at address 1280.
- Segment crossing, running 1200 blocks:
  - Block 1200 word 0 at 38400.
  - Its row-1 word 0 at 38480 (pitch 80).
  - Block 1800 word 0 at 57600.
- Frame end:
  - Block 2399 word 31 at 57600 + 239·80 + 79 = 76799.
  - WS_frame_done pulses with WS_done.
  - The next block writes at 0.
- Robustness:
  - WS_start asserted at cycle 30 mid-block: ignored.
  - resetn pulsed low at cycle 40: SRAM_we_n = 1 immediately, the next block writes at address 0, and WS_done does not appear until a new start.
